change_dispenser: RTL
=====================

# change_dispenser

Coin-return engine for the vending machine. Accepts a change amount in 5 rs units over a valid/ready handshake and drives the two coin hoppers (10 rs and 5 rs) one coin at a time. Uses a greedy algorithm and confirms every coin against the hopper drop sensor. Sits downstream of the vending FSM's change request and upstream of the hopper solenoid drivers.

## Interface
Parameters:
- AMT_W, 4, width of amount fields in 5 rs units (max 15 units = 75 rs)
- PULSE_CYCLES, 4, solenoid pulse width in clk cycles (>=1)
- TIMEOUT_CYCLES, 1000, max cycles from pulse start to drop-sensor pulse (>PULSE_CYCLES)

Ports (reset reset, asynchronous, active-high; clock clk):
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- req_valid  input  1  change request present
- req_amount  input  AMT_W  change owed, 5 rs units
- req_ready  output  1  high only in IDLE
- hopper10_empty  input  1  10 rs hopper has no coins (level)
- hopper5_empty  input  1  5 rs hopper has no coins (level)
- hopper_sense  input  1  single-cycle coin-drop pulse, already synchronised
- coin10_out  output  1  10 rs solenoid drive
- coin5_out  output  1  5 rs solenoid drive
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle completion strobe
- short_amt  output  AMT_W  undispensed units; valid when done=1, holds until next done
- fault  output  1  one-cycle, coincident with done, set on sensor timeout

## Operation
- States: IDLE, SELECT, PULSE, WAIT, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_amount into rem, then go to SELECT.
- SELECT applies the following rules in priority order:
  - rem>=2 and !hopper10_empty: den=10, go to PULSE.
  - rem>=1 and !hopper5_empty: den=5, go to PULSE. This covers rem=1, and rem>=2 when the 10 rs hopper is empty.
  - Otherwise (includes rem=0): go to DONE with short=rem.
- PULSE: drive the selected solenoid for exactly PULSE_CYCLES cycles, then go to WAIT. The timeout counter starts at the first PULSE cycle.
- WAIT: on hopper_sense, rem -= den units (2 or 1), then go to SELECT. A sense pulse that arrives during PULSE is also accepted: it is recorded, and the block proceeds to SELECT as soon as PULSE ends.
- Timeout: no sense within TIMEOUT_CYCLES of pulse start means go to DONE with fault=1 and short=rem (rem is not decremented).
- Sense pulses in IDLE, SELECT or DONE are ignored. A second sense pulse within the same coin is ignored.
- DONE: done=1 for one cycle, fault per above, short_amt register updated. Return to IDLE.
- Hopper-empty inputs are sampled only in SELECT. A hopper emptying mid-coin does not abort the current coin.
- Arithmetic: rem is AMT_W bits and never underflows, because den is chosen only when rem>=den.
- Reset values: req_ready=0 during reset then 1, busy=0, done=0, fault=0, coin10_out=0, coin5_out=0, short_amt=0, rem=0.
- Reset mid-operation: solenoids drop on the reset edge. rem is discarded and no done is issued.

## Timing
- Accept at edge T. SELECT occupies cycle T+1. Solenoid is high cycles T+2 .. T+1+PULSE_CYCLES. All outputs are registered.
- Sense at cycle S in WAIT: rem updates at edge S+1, SELECT at S+1, next pulse starts S+2.
- req_amount=0: SELECT at T+1, done at T+2, no pulse.
- coin10_out and coin5_out are never high simultaneously. There is at least one low cycle between consecutive pulses.
- req_ready falls the cycle after acceptance and returns the cycle after done.

## Configuration
- CHANGE_DISP_TIMEOUT_EN defined: the timeout counter and fault path are compiled in, as described above.
- CHANGE_DISP_TIMEOUT_EN undefined: WAIT waits indefinitely for hopper_sense, fault is tied 0, and TIMEOUT_CYCLES is unused.

## Structure
- Package change_disp_pkg holds:
  - the state enum (IDLE, SELECT, PULSE, WAIT, DONE)
  - denomination constants COIN10_UNITS=2 and COIN5_UNITS=1
  - the encoding of den
- Sub-module change_disp_timer: a loadable down-counter with a zero flag, instantiated twice.
  - Pulse-width instance: loaded with PULSE_CYCLES.
  - Timeout instance: loaded with TIMEOUT_CYCLES, present only under CHANGE_DISP_TIMEOUT_EN.
- Top level: FSM, rem register and output registers.

## Test plan
- Amount 7, both hoppers stocked, sense 2 cycles after each pulse ends -> pulses 10,10,10,5; done with short_amt=0, fault=0.
- Amount 3, hopper10_empty=1 -> three coin5_out pulses, zero coin10_out pulses; done with short_amt=0.
- Amount 1, hopper5_empty=1 -> no pulses; done at T+2 with short_amt=1, fault=0. Amount 0 -> done at T+2, short_amt=0.
- TIMEOUT_EN, amount 4, sense withheld on the second coin -> one 10 rs coin dispensed; done+fault exactly TIMEOUT_CYCLES after the second pulse start, short_amt=2.
- Reset asserted mid-PULSE with amount 5 -> coin output low immediately, no done. After release, req_ready=1 and a new amount 2 gives one 10 rs pulse.
- Sense during PULSE and a duplicate sense in WAIT -> rem decremented once per coin; final short_amt=0 for amount 2.

Source files
------------

// File: rtl/change_disp_pkg.sv
// change_disp_pkg: FSM states, coin denominations and den encoding shared by change_dispenser.
package change_disp_pkg;
   typedef enum logic [2:0] {IDLE, SELECT, PULSE, WAIT, DONE} state_e;
   typedef enum logic {DEN5, DEN10} den_e;
   localparam int COIN10_UNITS = 2;
   localparam int COIN5_UNITS  = 1;
   function automatic int den_units(den_e d);
      return (d == DEN10) ? COIN10_UNITS : COIN5_UNITS;
   endfunction
endpackage

// File: rtl/change_disp_timer.sv
// change_disp_timer: loadable down-counter; zero_o is high in the LOAD-th cycle after load_i.
module change_disp_timer #(
   parameter int LOAD = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   output logic zero_o
);
   localparam int W = $clog2(LOAD + 1);
   logic [W-1:0] cnt_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt_q <= '0;
      else if (load_i) cnt_q <= W'(LOAD - 1);
      else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
   assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: greedy 10/5 rs coin-return engine with drop-sensor confirmation.
// Define CHANGE_DISP_TIMEOUT_EN to compile in the sensor timeout and fault path.
module change_dispenser
   import change_disp_pkg::*;
#(
   parameter int AMT_W          = 4,
   parameter int PULSE_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   input  logic [AMT_W-1:0] req_amount,
   output logic             req_ready,
   input  logic             hopper10_empty,
   input  logic             hopper5_empty,
   input  logic             hopper_sense,
   output logic             coin10_out,
   output logic             coin5_out,
   output logic             busy,
   output logic             done,
   output logic [AMT_W-1:0] short_amt,
   output logic             fault
);
   state_e           state_q;
   den_e             den_q;
   logic [AMT_W-1:0] rem_q, short_q;
   logic             sensed_q, ready_q, busy_q, done_q, fault_q, c10_q, c5_q;
   logic             pulse_zero, to_zero;

   // Both timers reload throughout SELECT; the last load lands on the first PULSE cycle.
   change_disp_timer #(.LOAD(PULSE_CYCLES)) u_pulse (
      .clk(clk), .reset(reset), .load_i(state_q == SELECT), .zero_o(pulse_zero));
`ifdef CHANGE_DISP_TIMEOUT_EN
   change_disp_timer #(.LOAD(TIMEOUT_CYCLES)) u_timeout (
      .clk(clk), .reset(reset), .load_i(state_q == SELECT), .zero_o(to_zero));
`else
   // Never true: WAIT holds until the sensor fires.
   assign to_zero = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         den_q    <= DEN5;
         rem_q    <= '0;
         short_q  <= '0;
         sensed_q <= 1'b0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
         c10_q    <= 1'b0;
         c5_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               ready_q <= 1'b1;
               if (req_valid && ready_q) begin
                  rem_q   <= req_amount;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= SELECT;
               end
            end
            SELECT: begin
               sensed_q <= 1'b0;
               if (rem_q >= AMT_W'(COIN10_UNITS) && !hopper10_empty) begin
                  den_q   <= DEN10;
                  c10_q   <= 1'b1;
                  state_q <= PULSE;
               end else if (rem_q >= AMT_W'(COIN5_UNITS) && !hopper5_empty) begin
                  den_q   <= DEN5;
                  c5_q    <= 1'b1;
                  state_q <= PULSE;
               end else begin
                  short_q <= rem_q;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            PULSE: begin
               if (hopper_sense) sensed_q <= 1'b1;
               if (pulse_zero) begin
                  c10_q <= 1'b0;
                  c5_q  <= 1'b0;
                  if (sensed_q || hopper_sense) begin
                     rem_q   <= rem_q - AMT_W'(den_units(den_q));
                     state_q <= SELECT;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (hopper_sense) begin
                  rem_q   <= rem_q - AMT_W'(den_units(den_q));
                  state_q <= SELECT;
               end else if (to_zero) begin
                  short_q <= rem_q;
                  done_q  <= 1'b1;
                  fault_q <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: begin
               done_q  <= 1'b0;
               fault_q <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req_ready  = ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign fault      = fault_q;
   assign short_amt  = short_q;
   assign coin10_out = c10_q;
   assign coin5_out  = c5_q;
endmodule
